sw_mass_debounce: RTL
=====================

# sw_mass_debounce

Input conditioning stage for the two mass-select slide switches. It synchronises each raw switch line into the `clk` domain and rejects contact bounce with a per-bit stability counter. Its `out_port` drives the `in_port` of the mass-select PIO that the HPS reads over Avalon. It also emits a one-cycle change strobe per bit for local logic that needs edge events.

## Interface

Parameters:
- `WIDTH`, default 2: number of switch lines handled, each processed independently.
- `DEBOUNCE_CYCLES`, default 500000 (10 ms at 50 MHz): consecutive stable cycles required before a new level is accepted. Legal range is 1 to 2^24.
- `RESET_VALUE`, default 0 (a `WIDTH`-bit vector): value loaded into the accepted-level register on reset.

Ports:
- `clk`, input, 1 bit: single clock. All state is clocked on its rising edge.
- `reset`, input, 1 bit: asynchronous, active-high reset. It is released synchronously by the system reset controller.
- `sw_raw`, input, `WIDTH` bits: raw switch pins, asynchronous to `clk`.
- `out_port`, output, `WIDTH` bits: debounced, registered switch level. This feeds the PIO `in_port`.
- `changed`, output, `WIDTH` bits: one-cycle pulse per bit. It is asserted in the same cycle that `out_port[i]` takes a new value.

## Operation

Every bit `i` has the same independent datapath.
- **Synchroniser:** two flops, `s1[i] <= sw_raw[i]` then `s2[i] <= s1[i]`. Only `s2` is used downstream.
- **Counter:** `cnt[i]` has width `$clog2(DEBOUNCE_CYCLES)`, with a minimum of 1.
- **Accepted level:** `stable[i]`, which drives `out_port[i]`.

Per-bit rule, evaluated every rising edge:
- `s2[i] == stable[i]`: `cnt[i] <= 0`, `changed[i] <= 0`.
- `s2[i] != stable[i]` and `cnt[i] != DEBOUNCE_CYCLES-1`: `cnt[i] <= cnt[i]+1`, `changed[i] <= 0`.
- `s2[i] != stable[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i] <= s2[i]`, `cnt[i] <= 0`, `changed[i] <= 1`.

Rules that follow from this:
- Any return of `s2[i]` to `stable[i]` before terminal count (a bounce) clears the counter. Partial counts are never carried over.
- Bits are fully independent. Simultaneous transitions on several bits each follow their own counter. If they qualify on the same edge, `changed` carries several ones together.
- The counter never wraps. Terminal count always resolves to an update plus a clear.
- No enable input. The block is always active.

## Timing

Reset (asynchronous, active-high):
- `s1`, `s2` and `stable` are loaded with `RESET_VALUE`.
- `cnt` is cleared to 0.
- `changed` is cleared to 0.
- So after reset `out_port` = `RESET_VALUE` and `changed` = 0.

Reset asserted mid-count:
- Any partial count is discarded.
- No `changed` pulse is produced.
- After release, a switch held at a level other than `RESET_VALUE` is accepted through the normal full path: N+2 edges, with one `changed` pulse.

Latency, with N = `DEBOUNCE_CYCLES`:
- Count the edge at which `s1` first captures the new steady level as edge 1.
- `out_port` updates and `changed` pulses on edge N+2: two synchroniser edges plus N counting edges.
- Minimum case N=1: update on edge 3.

Glitch rejection and pulse width:
- A glitch whose synchronised width is ≤ N-1 cycles never reaches `out_port`.
- `changed` is high for exactly one cycle per accepted transition.
- Both outputs are registered, with no combinational path from `sw_raw`.

## Test plan

Benches use `WIDTH`=2, `DEBOUNCE_CYCLES`=4, `RESET_VALUE`=2'b00.
- **Reset and clean rise:** hold `reset`=1 with `sw_raw`=2'b11 → `out_port`=2'b00 and `changed`=0 throughout reset. Release and keep `sw_raw`=2'b11 → `out_port`=2'b11 and `changed`=2'b11 for one cycle, exactly 6 edges after the first post-reset sampling edge.
- **Bounce rejection:** drive `sw_raw[0]` as 1 for 3 cycles, 0 for 1, 1 for 2, 0 steady → `out_port[0]` stays 0 and `changed[0]` is never asserted.
- **Bounce then settle:** drive `sw_raw[1]` as 1,0,1,0 (one cycle each), then 1 steady → `out_port[1]` rises 6 edges after the final rising sample, with a single `changed[1]` pulse.
- **Independent bits:** raise `sw_raw[0]` at cycle 0 and `sw_raw[1]` at cycle 2, both steady → `changed`=2'b01 on edge 6, then 2'b10 on edge 8, with no overlap.
- **Reset mid-count:** raise `sw_raw[0]`, then assert `reset` for one cycle after 3 edges → `out_port[0]`=0 and `changed`=0 during and after reset. With `sw_raw[0]` still held at 1, `out_port[0]`=1 with one `changed[0]` pulse 6 edges after the first post-release sampling edge.
- **Falling transition:** from `out_port`=2'b11, drop both inputs to 0 → `out_port`=2'b00 on edge 6, with a one-cycle `changed`=2'b11.

Source files
------------

// File: rtl/sw_mass_debounce.sv
// Mass-select switch conditioning: per-line two-flop synchroniser plus stability
// counter, feeding the PIO in_port with a debounced level and a change strobe.

module sw_debounce_lane #(
    parameter int   CW        = 1,
    parameter int   TERM      = 0,
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic changed
);
    localparam logic [CW-1:0] TERM_CNT = CW'(TERM);

    logic          s1, s2, stable, chg;
    logic [CW-1:0] cnt;

    // Any bounce back to the accepted level clears cnt, so partial counts never carry over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1     <= RESET_BIT;
            s2     <= RESET_BIT;
            stable <= RESET_BIT;
            cnt    <= '0;
            chg    <= 1'b0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            chg <= 1'b0;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == TERM_CNT) begin
                stable <= s2;
                cnt    <= '0;
                chg    <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign level   = stable;
    assign changed = chg;
endmodule

module sw_mass_debounce #(
    parameter int               WIDTH           = 2,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] changed
);
    // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit for N=1.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        sw_debounce_lane #(
            .CW        (CW),
            .TERM      (DEBOUNCE_CYCLES - 1),
            .RESET_BIT (RESET_VALUE[i])
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .raw     (sw_raw[i]),
            .level   (out_port[i]),
            .changed (changed[i])
        );
    end
endmodule
